// File: rtl/ec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ec_pkg
//  Purpose  : Shared constants and types for the erasure-code bitmatrix
//             datapath (decode unit, XOR accumulator, bus interface).
//  Contents : W, PACKET_LENGTH, K, N_IN plus derived counter widths,
//             decode FSM state type and the packet type.
//  Revision : 1.0  initial release
// ============================================================================
package ec_pkg;

    // Bitmatrix word size: packets per strip and packets rebuilt per decode.
    localparam int W             = 4;
    // Bits carried by one packet.
    localparam int PACKET_LENGTH = 32;
    // Surviving strips consumed per decode.
    localparam int K             = 2;
    // Input packets per decode.
    localparam int N_IN          = K * W;

    // in_cnt must be able to hold N_IN itself so it never wraps mid-decode.
    localparam int CNT_W         = $clog2(N_IN + 1);
    // Row index width for the drain phase.
    localparam int IDX_W         = $clog2(W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } bm_dec_state_t;

    typedef logic [PACKET_LENGTH-1:0] packet_t;

endpackage : ec_pkg
`default_nettype wire

// File: rtl/bm_decode_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : bm_decode_unit_if
//  Purpose  : Control, input-stream and output-stream signals of the
//             bitmatrix decode unit, bundled with directional modports.
//  Ports    : master - host side (drives start, input stream, out_ready)
//             slave  - decode unit side
//  Signals  : start, busy, done
//             in_valid / in_ready / in_packet / in_coef
//             out_valid / out_ready / out_packet / out_idx / out_last
//  Revision : 1.0  initial release
// ============================================================================
interface bm_decode_unit_if;
    import ec_pkg::*;

    logic                 start;
    logic                 busy;
    logic                 done;

    logic                 in_valid;
    logic                 in_ready;
    packet_t              in_packet;
    logic [W-1:0]         in_coef;

    logic                 out_valid;
    logic                 out_ready;
    packet_t              out_packet;
    logic [IDX_W-1:0]     out_idx;
    logic                 out_last;

    modport master (
        output start,
        output in_valid,
        output in_packet,
        output in_coef,
        output out_ready,
        input  busy,
        input  done,
        input  in_ready,
        input  out_valid,
        input  out_packet,
        input  out_idx,
        input  out_last
    );

    modport slave (
        input  start,
        input  in_valid,
        input  in_packet,
        input  in_coef,
        input  out_ready,
        output busy,
        output done,
        output in_ready,
        output out_valid,
        output out_packet,
        output out_idx,
        output out_last
    );

endinterface : bm_decode_unit_if
`default_nettype wire

// File: rtl/bm_xor_accum.sv
`default_nettype none
// ============================================================================
//  Module   : bm_xor_accum
//  Purpose  : W packet-wide GF(2) accumulators. On en, every row whose coef
//             bit is set XORs pkt into its register. clr zeroes all rows
//             and takes priority over en.
//  Ports    : clk, rst_n  - clock / asynchronous active-low reset
//             clr         - synchronous clear of all rows
//             en          - accumulate enable (one input handshake)
//             coef[W]     - per-row select mask
//             pkt         - packet to fold in
//             acc         - all W accumulator values (registered)
//  Revision : 1.0  initial release
// ============================================================================
module bm_xor_accum
    import ec_pkg::*;
(
    input  wire logic                           clk,
    input  wire logic                           rst_n,
    input  wire logic                           clr,
    input  wire logic                           en,
    input  wire logic [W-1:0]                   coef,
    input  wire packet_t                        pkt,
    output logic      [W-1:0][PACKET_LENGTH-1:0] acc
);

    logic [W-1:0][PACKET_LENGTH-1:0] acc_q;
    logic [W-1:0][PACKET_LENGTH-1:0] acc_d;

    generate
        for (genvar r = 0; r < W; r++) begin : g_row
            always_comb begin
                acc_d[r] = acc_q[r];
                if (clr) begin
                    acc_d[r] = '0;
                end else if (en && coef[r]) begin
                    acc_d[r] = acc_q[r] ^ pkt;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q[r] <= '0;
                end else begin
                    acc_q[r] <= acc_d[r];
                end
            end
        end
    endgenerate

    assign acc = acc_q;

endmodule : bm_xor_accum
`default_nettype wire

// File: rtl/bm_decode_unit.sv
`default_nettype none
// ============================================================================
//  Module   : bm_decode_unit
//  Purpose  : Rebuilds W lost packets from K surviving strips. Accepts
//             N_IN = K*W packets, each with its decoding-bitmatrix column,
//             XOR-folds them into W row accumulators, then streams the W
//             reconstructed packets out in row order.
//  Ports    : clk   - single clock, all state on posedge
//             rst_n - asynchronous active-low reset
//             bus   - bm_decode_unit_if.slave (start/busy/done, input and
//                     output valid/ready streams)
//  Flow     : IDLE --start--> ACCUM --N_IN inputs--> DRAIN --W outputs--> IDLE
//  Revision : 1.0  initial release
// ============================================================================
module bm_decode_unit
    import ec_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst_n,
    bm_decode_unit_if.slave    bus
);

    localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(N_IN - 1);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(W - 1);

    bm_dec_state_t      state_q,   state_d;
    logic [CNT_W-1:0]   in_cnt_q,  in_cnt_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic               done_q,    done_d;

    logic               acc_clr;
    logic               acc_en;
    logic               in_ready;
    logic               out_valid;
    logic               out_last;
    logic               in_hs;
    logic               out_hs;

    logic [W-1:0][PACKET_LENGTH-1:0] acc;

    // Handshake-facing outputs are pure decodes of registered state, so
    // nothing on the output side depends combinationally on the inputs.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DRAIN);
    assign out_last  = out_valid && (out_idx_q == LAST_ROW);
    assign in_hs     = bus.in_valid  && in_ready;
    assign out_hs    = bus.out_ready && out_valid;

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_idx_d = out_idx_q;
        done_d    = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;

        case (state_q)
            IDLE: begin
                // start is only meaningful here; elsewhere it falls through.
                if (bus.start) begin
                    acc_clr   = 1'b1;
                    in_cnt_d  = '0;
                    out_idx_d = '0;
                    state_d   = ACCUM;
                end
            end

            ACCUM: begin
                if (in_hs) begin
                    acc_en   = 1'b1;
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == LAST_IN) begin
                        out_idx_d = '0;
                        state_d   = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (out_hs) begin
                    if (out_idx_q == LAST_ROW) begin
                        out_idx_d = '0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        out_idx_d = out_idx_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            out_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_idx_q <= out_idx_d;
            done_q    <= done_d;
        end
    end

    bm_xor_accum u_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (acc_en),
        .coef  (bus.in_coef),
        .pkt   (bus.in_packet),
        .acc   (acc)
    );

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_last   = out_last;
    assign bus.out_idx    = out_idx_q;
    assign bus.out_packet = acc[out_idx_q];
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;

endmodule : bm_decode_unit
`default_nettype wire

// File: tb/tb_bm_decode_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bm_decode_unit
//  Purpose  : Directed self-checking bench for bm_decode_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bm_decode_unit;
    import ec_pkg::*;

    typedef packet_t      pvec_t [N_IN];
    typedef logic [W-1:0] cvec_t [N_IN];
    typedef packet_t      ovec_t [W];
    typedef logic [IDX_W-1:0] ivec_t [W];

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    bm_decode_unit_if bus ();

    bm_decode_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus vectors
    pvec_t id_pk;
    cvec_t id_cf;
    pvec_t mx_pk;
    cvec_t mx_cf;
    ovec_t id_exp;
    ovec_t mx_exp;

    // ---------------- drivers (no checking) ----------------
    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Presents n packets; gap idle cycles before each. start is raised
    // together with packet start_at (-1: never).
    task automatic feed(input pvec_t pk, input cvec_t cf, input int n,
                        input int gap, input int start_at, output int to);
        to = 0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            bus.in_valid  = 1'b1;
            bus.in_packet = pk[i];
            bus.in_coef   = cf[i];
            bus.start     = (i == start_at);
            begin
                int b;
                b = 0;
                while (bus.in_ready !== 1'b1 && b < 20) begin
                    @(negedge clk);
                    b++;
                end
                if (b >= 20) to++;
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    // Collects W outputs, holding out_ready low for stall cycles per packet
    // and counting any instability while stalled. Returns at the cycle just
    // after the final output handshake.
    task automatic collect(input int stall, output ovec_t got, output ivec_t idx,
                           output int lastm, output int serr, output int to,
                           output logic done_now);
        to = 0; serr = 0; lastm = 0;
        for (int k = 0; k < W; k++) begin
            packet_t p;
            logic [IDX_W-1:0] ix;
            int b;
            bus.out_ready = 1'b0;
            b = 0;
            while (bus.out_valid !== 1'b1 && b < 20) begin
                @(negedge clk);
                b++;
            end
            if (b >= 20) to++;
            p  = bus.out_packet;
            ix = bus.out_idx;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                if (bus.out_packet !== p || bus.out_idx !== ix ||
                    bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) serr++;
            end
            got[k] = p;
            idx[k] = ix;
            if (bus.out_last === 1'b1) lastm |= (1 << k);
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
        done_now = bus.done;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", bus.out_last); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        total++; if (bus.out_idx !== '0) begin bad++; $display("FAIL reset_out_idx got=%0d exp=0", bus.out_idx); end
        total++; if (bus.out_packet !== '0) begin bad++; $display("FAIL reset_out_packet got=%h exp=0", bus.out_packet); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
    endtask

    // Full decode plus all output checks; name tags the FAIL lines.
    task automatic run_decode(input string name, input pvec_t pk, input cvec_t cf,
                              input ovec_t exp, input int gap, input int stall,
                              input int start_at, input bit check_latency,
                              output logic done_now);
        int to_in, to_out, lastm, serr;
        ovec_t got;
        ivec_t idx;
        feed(pk, cf, N_IN, gap, start_at, to_in);
        total++; if (to_in !== 0) begin bad++; $display("FAIL %s_in_timeout got=%0d exp=0", name, to_in); end
        if (check_latency) begin
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL %s_first_out_valid got=%b exp=1", name, bus.out_valid); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL %s_drain_in_ready got=%b exp=0", name, bus.in_ready); end
        end
        collect(stall, got, idx, lastm, serr, to_out, done_now);
        total++; if (to_out !== 0) begin bad++; $display("FAIL %s_out_timeout got=%0d exp=0", name, to_out); end
        for (int k = 0; k < W; k++) begin
            total++; if (got[k] !== exp[k]) begin bad++; $display("FAIL %s_out%0d got=%h exp=%h", name, k, got[k], exp[k]); end
            total++; if (idx[k] !== IDX_W'(k)) begin bad++; $display("FAIL %s_idx%0d got=%0d exp=%0d", name, k, idx[k], k); end
        end
        total++; if (lastm !== 8) begin bad++; $display("FAIL %s_last_mask got=%h exp=8", name, lastm); end
        total++; if (serr !== 0) begin bad++; $display("FAIL %s_stall_stable got=%0d exp=0", name, serr); end
        total++; if (done_now !== 1'b1) begin bad++; $display("FAIL %s_done got=%b exp=1", name, done_now); end
    endtask

    task automatic check_done_drops(input string name);
        @(negedge clk);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL %s_done_pulse got=%b exp=0", name, bus.done); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s_idle_busy got=%b exp=0", name, bus.busy); end
    endtask

    task automatic test_identity();
        logic d;
        pulse_start();
        total++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL ident_accum_entry got=%b%b exp=11", bus.busy, bus.in_ready); end
        run_decode("ident", id_pk, id_cf, id_exp, 0, 0, -1, 1'b1, d);
        check_done_drops("ident");
    endtask

    task automatic test_xor_mix();
        logic d;
        pulse_start();
        run_decode("mix", mx_pk, mx_cf, mx_exp, 0, 0, -1, 1'b1, d);
        check_done_drops("mix");
    endtask

    task automatic test_backpressure();
        logic d;
        pulse_start();
        run_decode("bp", mx_pk, mx_cf, mx_exp, 1, 3, -1, 1'b0, d);
        check_done_drops("bp");
    endtask

    task automatic test_start_ignored();
        logic d;
        pulse_start();
        run_decode("startign", mx_pk, mx_cf, mx_exp, 0, 0, 3, 1'b1, d);
        check_done_drops("startign");
    endtask

    task automatic test_reset_mid();
        int to;
        logic d;
        pulse_start();
        feed(mx_pk, mx_cf, 5, 0, -1, to);
        total++; if (to !== 0 || bus.busy !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%0d/%b exp=0/1", to, bus.busy); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_in_ready got=%b exp=0", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        run_decode("rstmid", id_pk, id_cf, id_exp, 0, 0, -1, 1'b1, d);
        check_done_drops("rstmid");
    endtask

    task automatic test_back_to_back();
        logic d;
        pulse_start();
        run_decode("b2b_first", mx_pk, mx_cf, mx_exp, 0, 0, -1, 1'b1, d);
        // start raised in the done cycle
        pulse_start();
        total++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_restart got=%b%b exp=11", bus.busy, bus.in_ready); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_done_pulse got=%b exp=0", bus.done); end
        run_decode("b2b_second", id_pk, id_cf, id_exp, 0, 0, -1, 1'b1, d);
        check_done_drops("b2b");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_packet = '0;
        bus.in_coef   = '0;
        bus.out_ready = 1'b0;

        id_pk  = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
                   32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
        id_cf  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
        id_exp = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333};
        mx_pk  = '{32'h00000001, 32'h00000002, 32'h00000004, 32'h00000008,
                   32'h00000010, 32'h00000020, 32'h00000040, 32'h00000080};
        mx_cf  = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        mx_exp = '{32'h000000FF, 32'h000000FF, 32'h000000FF, 32'h000000FF};

        @(negedge clk);
        test_reset();
        test_identity();
        test_xor_mix();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bm_decode_unit
`default_nettype wire
